// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   - ALU opcode encodings understood by alu_arbiter_alu
//   - arbiter FSM state encoding used by alu_arbiter
package alu_arbiter_pkg;

    // ALU opcodes; any other value produces a zero result.
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLL  = 2;
    localparam int ALU_SLT  = 3;
    localparam int ALU_SLTU = 4;
    localparam int ALU_XOR  = 5;
    localparam int ALU_SRL  = 6;
    localparam int ALU_SRA  = 7;
    localparam int ALU_OR   = 8;
    localparam int ALU_AND  = 9;
    localparam int ALU_EQ   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by all requesters of alu_arbiter.
// Ports:
//   rst_x  in   1     active-low reset; forces the result to zero while low
//   op     in   OPW   opcode (see alu_arbiter_pkg)
//   lhs    in   XLEN  left operand
//   rhs    in   XLEN  right operand; low bits are the shift amount for shifts
//   res    out  XLEN  result
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int XLEN = 32
) (
    input  logic            rst_x,
    input  logic [OPW-1:0]  op,
    input  logic [XLEN-1:0] lhs,
    input  logic [XLEN-1:0] rhs,
    output logic [XLEN-1:0] res
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = rhs[SHW-1:0];

    always_comb begin
        // NOTE: default assignment first so no path leaves res unassigned (no latch).
        res = '0;
        if (rst_x) begin
            case (int'(op))
                ALU_ADD:  res = lhs + rhs;
                ALU_SUB:  res = lhs - rhs;
                ALU_SLL:  res = lhs << shamt;
                ALU_SLT:  res = {{(XLEN-1){1'b0}}, $signed(lhs) < $signed(rhs)};
                ALU_SLTU: res = {{(XLEN-1){1'b0}}, lhs < rhs};
                ALU_XOR:  res = lhs ^ rhs;
                ALU_SRL:  res = lhs >> shamt;
                ALU_SRA:  res = $unsigned($signed(lhs) >>> shamt);
                ALU_OR:   res = lhs | rhs;
                ALU_AND:  res = lhs & rhs;
                ALU_EQ:   res = {{(XLEN-1){1'b0}}, lhs == rhs};
                default:  res = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters.
// One operation in flight; the result is registered and held until taken.
// Ports:
//   CLK        in   1          clock, rising edge
//   RST_X      in   1          synchronous reset, active-low
//   req_valid  in   NREQ       requester i presents an operation
//   req_ready  out  NREQ       one-hot grant, only in IDLE
//   req_op     in   NREQ*OPW   opcode, slice i = [i*OPW +: OPW]
//   req_lhs    in   NREQ*XLEN  left operand, slice i
//   req_rhs    in   NREQ*XLEN  right operand, slice i
//   rsp_valid  out  NREQ       one-hot, result for requester gnt on rsp_data
//   rsp_ready  in   NREQ       requester takes the result (only bit gnt is used)
//   rsp_data   out  XLEN       shared result bus
//   busy       out  1          operation in EXEC or RESP
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int OPW  = 5,
    parameter int XLEN = 32
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OPW-1:0]  req_op,
    input  logic [NREQ*XLEN-1:0] req_lhs,
    input  logic [NREQ*XLEN-1:0] req_rhs,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]      rsp_data,
    output logic                 busy
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef logic [PTRW-1:0] idx_t;

    typedef struct packed {
        logic hit;
        idx_t idx;
    } pick_t;

    // First valid requester at or after p, wrapping modulo NREQ. Walking the
    // offsets downward lets the nearest candidate overwrite farther ones.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] v, input idx_t p);
        pick_t r;
        int    c;
        r = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            c = (int'(p) + k) % NREQ;
            if (v[c]) begin
                r.hit = 1'b1;
                r.idx = idx_t'(c);
            end
        end
        return r;
    endfunction

    arb_state_t      state;
    idx_t            ptr;
    idx_t            gnt;
    logic [OPW-1:0]  op_q;
    logic [XLEN-1:0] lhs_q;
    logic [XLEN-1:0] rhs_q;
    logic [XLEN-1:0] alu_res;
    pick_t           pick;

    alu_arbiter_alu #(
        .OPW  (OPW),
        .XLEN (XLEN)
    ) u_alu (
        .rst_x (RST_X),
        .op    (op_q),
        .lhs   (lhs_q),
        .rhs   (rhs_q),
        .res   (alu_res)
    );

    // Handshake outputs are decoded from state and gated by RST_X so they read
    // inactive for the whole reset interval, not just after the first edge.
    always_comb begin
        pick      = rr_pick(req_valid, ptr);
        req_ready = '0;
        rsp_valid = '0;
        if (RST_X && state == IDLE && pick.hit)
            req_ready[pick.idx] = 1'b1;
        if (RST_X && state == RESP)
            rsp_valid[gnt] = 1'b1;
        busy = RST_X && (state == EXEC || state == RESP);
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            // NOTE: operand/result registers are reset too, so no stale data survives a mid-op reset.
            state    <= IDLE;
            ptr      <= '0;
            gnt      <= '0;
            op_q     <= '0;
            lhs_q    <= '0;
            rhs_q    <= '0;
            rsp_data <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (pick.hit) begin
                        gnt   <= pick.idx;
                        op_q  <= req_op [pick.idx*OPW  +: OPW];
                        lhs_q <= req_lhs[pick.idx*XLEN +: XLEN];
                        rhs_q <= req_rhs[pick.idx*XLEN +: XLEN];
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data <= alu_res;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready[gnt]) begin
                        ptr   <= (gnt == idx_t'(NREQ - 1)) ? '0 : gnt + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (NREQ=2). Expected results are pushed
// to a scoreboard when a request is accepted and popped when the response
// is taken.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NREQ = 2;
    localparam int OPW  = 5;
    localparam int XLEN = 32;

    logic                 CLK = 1'b0;
    logic                 RST_X = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*OPW-1:0]  req_op = '0;
    logic [NREQ*XLEN-1:0] req_lhs = '0;
    logic [NREQ*XLEN-1:0] req_rhs = '0;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready = '0;
    logic [XLEN-1:0]      rsp_data;
    logic                 busy;

    alu_arbiter #(.NREQ(NREQ), .OPW(OPW), .XLEN(XLEN)) dut (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_lhs   (req_lhs),
        .req_rhs   (req_rhs),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int              idx;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU, written independently of the RTL.
    function automatic logic [XLEN-1:0] alu_ref(input logic [OPW-1:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (int'(op))
            ALU_ADD:  return a + b;
            ALU_SUB:  return a + ~b + 32'd1;
            ALU_SLL:  return a << s;
            ALU_SLT:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            ALU_SLTU: return {31'd0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> s;
            ALU_SRA:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_EQ:   return {31'd0, a == b};
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input int i, input int op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b);
        req_op [i*OPW  +: OPW]  = OPW'(op);
        req_lhs[i*XLEN +: XLEN] = a;
        req_rhs[i*XLEN +: XLEN] = b;
    endtask

    // Entered shortly after a negedge with the DUT in IDLE. Drives valid,
    // expects exp_idx to be granted, holds the response for `hold` cycles
    // (driving rsp_ready only on non-granted bits), then takes it.
    task automatic issue(input string tag, input logic [NREQ-1:0] valid,
                         input logic [NREQ-1:0] exec_valid, input int exp_idx,
                         input int hold);
        exp_t e;
        req_valid = valid;
        #1;
        check({tag, " req_ready"}, req_ready, onehot(exp_idx));
        e.idx  = exp_idx;
        e.data = alu_ref(req_op[exp_idx*OPW +: OPW], req_lhs[exp_idx*XLEN +: XLEN],
                         req_rhs[exp_idx*XLEN +: XLEN]);
        sb.push_back(e);

        @(negedge CLK);
        req_valid = exec_valid;
        #1;
        check({tag, " exec busy"}, busy, 1'b1);
        check({tag, " exec rsp_valid"}, rsp_valid, '0);
        check({tag, " exec req_ready"}, req_ready, '0);

        @(negedge CLK);
        req_valid = valid;
        rsp_ready = ~onehot(exp_idx);
        #1;
        for (int h = 0; h < hold; h++) begin
            check({tag, " hold rsp_valid"}, rsp_valid, onehot(exp_idx));
            check({tag, " hold rsp_data"}, rsp_data, sb[0].data);
            check({tag, " hold req_ready"}, req_ready, '0);
            check({tag, " hold busy"}, busy, 1'b1);
            @(negedge CLK);
            #1;
        end
        rsp_ready = onehot(exp_idx);
        #1;
        e = sb.pop_front();
        check({tag, " rsp_valid"}, rsp_valid, onehot(e.idx));
        check({tag, " rsp_data"}, rsp_data, e.data);

        @(negedge CLK);
        rsp_ready = '0;
        #1;
        check({tag, " rsp dropped"}, rsp_valid, '0);
        check({tag, " idle busy"}, busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state with requests pending.
        RST_X     = 1'b0;
        req_valid = 2'b11;
        repeat (3) @(negedge CLK);
        #1;
        check("reset req_ready", req_ready, '0);
        check("reset rsp_valid", rsp_valid, '0);
        check("reset busy", busy, 1'b0);
        check("reset rsp_data", rsp_data, '0);
        req_valid = '0;
        RST_X     = 1'b1;
        @(negedge CLK);

        // 1: single request r0 ADD 5+7.
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        issue("single", 2'b01, 2'b01, 0, 0);
        check("single data", rsp_data, 32'd12);

        // Return ptr to 0 before contention.
        RST_X = 1'b0;
        @(negedge CLK);
        RST_X = 1'b1;

        // 2: contention, r0 first, then r1, then r0 again.
        set_req(0, ALU_ADD, 32'd1, 32'd1);
        set_req(1, ALU_SUB, 32'd9, 32'd4);
        issue("contend r0", 2'b11, 2'b11, 0, 0);
        check("contend r0 data", rsp_data, 32'd2);
        issue("contend r1", 2'b11, 2'b11, 1, 0);
        check("contend r1 data", rsp_data, 32'd5);

        // 3: backpressure on r0 SLT -1 < 1, r1 still requesting.
        set_req(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        issue("backpressure", 2'b11, 2'b11, 0, 10);
        check("backpressure data", rsp_data, 32'd1);

        // 4: reset during EXEC drops the operation.
        set_req(0, ALU_ADD, 32'd3, 32'd4);
        req_valid = 2'b01;
        #1;
        check("midreset req_ready", req_ready, 2'b01);
        @(negedge CLK);
        #1;
        check("midreset exec busy", busy, 1'b1);
        RST_X     = 1'b0;
        req_valid = '0;
        @(negedge CLK);
        #1;
        check("midreset rsp_valid", rsp_valid, '0);
        check("midreset busy", busy, 1'b0);
        check("midreset rsp_data", rsp_data, '0);
        RST_X = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            #1;
            check("post-reset rsp_valid", rsp_valid, '0);
            check("post-reset busy", busy, 1'b0);
        end
        set_req(1, ALU_XOR, 32'hF0F0_0000, 32'h0FF0_1234);
        issue("post-reset ptr0", 2'b11, 2'b11, 0, 0);

        // 5: r1 pulses valid only while busy and must never be served.
        set_req(0, ALU_SRA, 32'h8000_0010, 32'd4);
        issue("withdraw", 2'b01, 2'b11, 0, 2);
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            #1;
            check("withdraw req_ready", req_ready, '0);
            check("withdraw rsp_valid", rsp_valid, '0);
        end

        // 6: fairness soak; ptr is 1 here so r1 leads, then strict alternation.
        for (int k = 0; k < 1000; k++) begin
            set_req(0, int'($urandom_range(0, 12)), $urandom, $urandom);
            set_req(1, int'($urandom_range(0, 12)), $urandom, $urandom);
            issue("soak", 2'b11, 2'b11, (k % 2 == 0) ? 1 : 0, int'($urandom_range(0, 2)));
        end
        check("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
